// File: rtl/cordic_floatingpoint_addsub_normalize_if.sv
// Handshake and data bundle between the mantissa adder, the post-add normalizer and its consumer.
// The slave modport is the normalizer's view; the master modport is the upstream/downstream view.
interface cordic_floatingpoint_addsub_normalize_if #(
    parameter int MANT_W = 24,
    parameter int EXP_W  = 8
);
    logic                in_valid;
    logic                in_ready;
    logic [MANT_W+1:0]   in_sum;
    logic [EXP_W-1:0]    in_exp;
    logic                out_valid;
    logic                out_ready;
    logic                out_sign;
    logic [EXP_W-1:0]    out_exp;
    logic [MANT_W-2:0]   out_mant;
    logic                out_zero;
    logic                out_ovf;
    logic                out_unf;

    modport slave (
        input  in_valid, in_sum, in_exp, out_ready,
        output in_ready, out_valid, out_sign, out_exp, out_mant,
               out_zero, out_ovf, out_unf
    );

    modport master (
        output in_valid, in_sum, in_exp, out_ready,
        input  in_ready, out_valid, out_sign, out_exp, out_mant,
               out_zero, out_ovf, out_unf
    );
endinterface

// File: rtl/cordic_floatingpoint_addsub_normalize.sv
// Post-add normalizer: signed mantissa sum -> sign/magnitude, leading-one shift, exponent adjust.
// Latency 2 cycles (S1 magnitude/LZC, S2 shift + output regs), 1 result/cycle unstalled.
// Backpressure: both stages stall on !out_ready, holding up to 2 items; CORDIC_FP_NORM_SAT_EN saturates ovf/unf.
module cordic_floatingpoint_addsub_normalize #(
    parameter int MANT_W = 24,
    parameter int EXP_W  = 8
) (
    input  logic clk,
    input  logic rst_n,
    cordic_floatingpoint_addsub_normalize_if.slave bus
);
    localparam int KW = $clog2(MANT_W);

    typedef struct packed {
        logic              sign;
        logic [EXP_W-1:0]  exp;
        logic [MANT_W-2:0] mant;
        logic              zero;
        logic              ovf;
        logic              unf;
    } res_t;

    logic              s1_valid_q, s1_valid_d;
    logic              s1_sign_q,  s1_sign_d;
    logic [MANT_W:0]   s1_mag_q,   s1_mag_d;
    logic [KW-1:0]     s1_k_q,     s1_k_d;
    logic [EXP_W-1:0]  s1_exp_q,   s1_exp_d;
    logic              s2_valid_q, s2_valid_d;
    res_t              res_q,      res_d;

    logic              s2_load;
    logic              s1_adv;
    logic              in_rdy;
    logic              accept;
    logic [MANT_W:0]   mag_in;
    logic [KW-1:0]     lz_in;
    logic              zero_n;
    logic              carry_n;
    logic [EXP_W:0]    exp_ext;
    logic [MANT_W-1:0] mant_n;
    logic              ovf_n;
    logic              unf_n;

    always_comb begin
        s2_load = !s2_valid_q || bus.out_ready;
        s1_adv  = s1_valid_q && s2_load;
        in_rdy  = !s1_valid_q || s1_adv;
        accept  = bus.in_valid && in_rdy;
    end

    // Only the low MANT_W+1 bits of the magnitude are legal, so negate just those bits.
    always_comb begin
        mag_in = bus.in_sum[MANT_W+1] ? (~bus.in_sum[MANT_W:0] + 1'b1) : bus.in_sum[MANT_W:0];
        lz_in  = KW'(MANT_W - 1);
        for (int i = 0; i < MANT_W; i++) begin
            if (mag_in[i]) lz_in = KW'(MANT_W - 1 - i);
        end
    end

    always_comb begin
        s1_valid_d = s1_valid_q;
        s1_sign_d  = s1_sign_q;
        s1_mag_d   = s1_mag_q;
        s1_k_d     = s1_k_q;
        s1_exp_d   = s1_exp_q;
        if (accept) begin
            s1_valid_d = 1'b1;
            s1_sign_d  = bus.in_sum[MANT_W+1];
            s1_mag_d   = mag_in;
            s1_k_d     = lz_in;
            s1_exp_d   = bus.in_exp;
        end else if (s1_adv) begin
            s1_valid_d = 1'b0;
        end
    end

    always_comb begin
        zero_n  = (s1_mag_q == '0);
        carry_n = s1_mag_q[MANT_W];
        exp_ext = carry_n ? ({1'b0, s1_exp_q} + 1'b1)
                          : ({1'b0, s1_exp_q} - (EXP_W+1)'(s1_k_q));
        mant_n  = carry_n ? s1_mag_q[MANT_W:1] : (s1_mag_q[MANT_W-1:0] << s1_k_q);
        ovf_n   = !zero_n && carry_n && exp_ext[EXP_W];
        unf_n   = !zero_n && !carry_n && ((EXP_W+1)'(s1_k_q) >= {1'b0, s1_exp_q});
    end

    always_comb begin
        res_d      = res_q;
        s2_valid_d = s2_valid_q;
        if (s2_load) begin
            s2_valid_d = s1_valid_q;
            if (s1_valid_q) begin
                res_d.sign = s1_sign_q;
                res_d.exp  = exp_ext[EXP_W-1:0];
                res_d.mant = mant_n[MANT_W-2:0];
                res_d.zero = 1'b0;
                res_d.ovf  = ovf_n;
                res_d.unf  = unf_n;
`ifdef CORDIC_FP_NORM_SAT_EN
                if (ovf_n) begin
                    res_d.exp  = '1;
                    res_d.mant = '0;
                end
                if (unf_n) begin
                    res_d.exp  = '0;
                    res_d.mant = '0;
                end
`endif
                if (zero_n) begin
                    res_d = '0;
                    res_d.zero = 1'b1;
                end
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            s1_valid_q <= 1'b0;
            s1_sign_q  <= 1'b0;
            s1_mag_q   <= '0;
            s1_k_q     <= '0;
            s1_exp_q   <= '0;
            s2_valid_q <= 1'b0;
            res_q      <= '0;
        end else begin
            s1_valid_q <= s1_valid_d;
            s1_sign_q  <= s1_sign_d;
            s1_mag_q   <= s1_mag_d;
            s1_k_q     <= s1_k_d;
            s1_exp_q   <= s1_exp_d;
            s2_valid_q <= s2_valid_d;
            res_q      <= res_d;
        end
    end

    assign bus.in_ready  = in_rdy;
    assign bus.out_valid = s2_valid_q;
    assign bus.out_sign  = res_q.sign;
    assign bus.out_exp   = res_q.exp;
    assign bus.out_mant  = res_q.mant;
    assign bus.out_zero  = res_q.zero;
    assign bus.out_ovf   = res_q.ovf;
    assign bus.out_unf   = res_q.unf;
endmodule

// File: tb/tb_cordic_floatingpoint_addsub_normalize.sv
// Bench for the post-add normalizer: directed vectors, literal expectations and a
// queue-based arithmetic model checked against the output on every valid cycle.
module tb_cordic_floatingpoint_addsub_normalize;
    localparam int MANT_W = 24;
    localparam int EXP_W  = 8;

    typedef struct packed {
        logic        sign;
        logic [7:0]  exp;
        logic [22:0] mant;
        logic        zero;
        logic        ovf;
        logic        unf;
    } res_t;

    logic clk = 1'b0;
    logic rst_n;
    always #5 clk = ~clk;

    cordic_floatingpoint_addsub_normalize_if #(.MANT_W(MANT_W), .EXP_W(EXP_W)) bus ();

    cordic_floatingpoint_addsub_normalize #(.MANT_W(MANT_W), .EXP_W(EXP_W)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    int n_cmp  = 0;
    int n_fail = 0;
    int n_push = 0;
    int n_pop  = 0;
    res_t q[$];
    logic [25:0] vs_sum [12];
    logic [7:0]  vs_exp [12];

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] req);
        n_cmp++;
        if (act !== req) begin
            n_fail++;
            $display("FAIL %s: got %0h, expected %0h", name, act, req);
        end
    endtask

    function automatic res_t dut_res();
        return {bus.out_sign, bus.out_exp, bus.out_mant, bus.out_zero, bus.out_ovf, bus.out_unf};
    endfunction

    // Real-valued view: value = sum * 2^(exp-bias) scale; renormalize until 1.f form.
    function automatic res_t model(input logic [25:0] sum, input logic [7:0] ex);
        res_t   r;
        longint v, m, e;
        v = longint'({38'd0, sum});
        if (sum[25]) v = v - (longint'(1) << 26);
        r = '0;
        if (v == 0) begin
            r.zero = 1'b1;
            return r;
        end
        r.sign = (v < 0);
        m = (v < 0) ? -v : v;
        e = longint'({56'd0, ex});
        if (m >= (longint'(1) << 24)) begin
            m = m >> 1;
            e = e + 1;
        end else begin
            while (m < (longint'(1) << 23)) begin
                m = m << 1;
                e = e - 1;
            end
        end
        r.ovf  = (e > 255);
        r.unf  = (e <= 0);
        r.exp  = e[7:0];
        r.mant = m[22:0];
`ifdef CORDIC_FP_NORM_SAT_EN
        if (r.ovf) begin r.exp = 8'hFF; r.mant = '0; end
        if (r.unf) begin r.exp = 8'h00; r.mant = '0; end
`endif
        return r;
    endfunction

    always @(negedge clk) begin
        if (!rst_n) begin
            q.delete();
        end else begin
            if (bus.out_valid) begin
                if (q.size() == 0) begin
                    n_cmp++;
                    n_fail++;
                    $display("FAIL sb_unexpected: got result %0h, expected no output", dut_res());
                end else begin
                    chk("sb_result", dut_res(), q[0]);
                    if (bus.out_ready) begin
                        void'(q.pop_front());
                        n_pop++;
                    end
                end
            end
            if (bus.in_valid && bus.in_ready) begin
                q.push_back(model(bus.in_sum, bus.in_exp));
                n_push++;
            end
        end
    end

    task automatic single(input string name, input logic [25:0] sum, input logic [7:0] ex,
                          input res_t req);
        chk({name, "_model"}, model(sum, ex), req);
        bus.in_valid = 1'b1; bus.in_sum = sum; bus.in_exp = ex; bus.out_ready = 1'b1;
        chk({name, "_in_ready"}, bus.in_ready, 1);
        @(posedge clk); #1;
        bus.in_valid = 1'b0;
        chk({name, "_lat1"}, bus.out_valid, 0);
        @(posedge clk); #1;
        chk({name, "_valid"}, bus.out_valid, 1);
        chk({name, "_res"}, dut_res(), req);
        @(posedge clk); #1;
    endtask

    task automatic stream(input int first, input int cnt, input int mode, output int cycles);
        int idx = first;
        int c = 0;
        while (idx < first + cnt && c < 200) begin
            bus.in_valid  = 1'b1;
            bus.in_sum    = vs_sum[idx];
            bus.in_exp    = vs_exp[idx];
            bus.out_ready = (mode == 0) ? 1'b1 : ((c % 3) != 2);
            @(negedge clk);
            if (bus.in_ready) idx++;
            @(posedge clk); #1;
            c++;
        end
        bus.in_valid = 1'b0;
        cycles = c;
        if (c >= 200) begin
            n_cmp++; n_fail++;
            $display("FAIL stream_timeout: got %0d accepted, expected %0d", idx - first, cnt);
        end
    endtask

    task automatic drain();
        int g = 0;
        bus.out_ready = 1'b1;
        while (q.size() != 0 && g < 50) begin
            @(posedge clk); #1;
            g++;
        end
        if (g >= 50) begin
            n_cmp++; n_fail++;
            $display("FAIL drain_timeout: got %0d pending, expected 0", q.size());
        end
    endtask

    initial begin
        int cyc;
        int idx;
        int pop0;
        res_t r6a, r6b;

        vs_sum[0]  = 26'h0800000; vs_exp[0]  = 8'd127;
        vs_sum[1]  = 26'h1FFFFFF; vs_exp[1]  = 8'd254;
        vs_sum[2]  = 26'h2000001; vs_exp[2]  = 8'd100;
        vs_sum[3]  = 26'h0000001; vs_exp[3]  = 8'd30;
        vs_sum[4]  = 26'h3000000; vs_exp[4]  = 8'd60;
        vs_sum[5]  = 26'h0123456; vs_exp[5]  = 8'd140;
        vs_sum[6]  = 26'h0000000; vs_exp[6]  = 8'd5;
        vs_sum[7]  = 26'h3ABCDEF; vs_exp[7]  = 8'd77;
        vs_sum[8]  = 26'h1000000; vs_exp[8]  = 8'd255;
        vs_sum[9]  = 26'h0000010; vs_exp[9]  = 8'd4;
        vs_sum[10] = 26'h0FFFFFF; vs_exp[10] = 8'd200;
        vs_sum[11] = 26'h3FFFF00; vs_exp[11] = 8'd128;

`ifdef CORDIC_FP_NORM_SAT_EN
        r6a = {1'b0, 8'd255, 23'd0, 1'b0, 1'b1, 1'b0};
        r6b = {1'b0, 8'd0,   23'd0, 1'b0, 1'b0, 1'b1};
`else
        r6a = {1'b0, 8'd0,   23'd0, 1'b0, 1'b1, 1'b0};
        r6b = {1'b0, 8'd236, 23'd0, 1'b0, 1'b0, 1'b1};
`endif

        rst_n = 1'b0;
        bus.in_valid = 1'b0; bus.in_sum = '0; bus.in_exp = '0; bus.out_ready = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        chk("rst_out_valid", bus.out_valid, 0);
        chk("rst_outputs", dut_res(), 0);
        rst_n = 1'b1;
        @(posedge clk); #1;
        chk("rst_in_ready", bus.in_ready, 1);

        single("t1_unity",   26'h0800000, 8'd127, {1'b0, 8'd127, 23'd0, 1'b0, 1'b0, 1'b0});
        single("t2_carry",   26'h1000000, 8'd127, {1'b0, 8'd128, 23'd0, 1'b0, 1'b0, 1'b0});
        single("t3_neg1",    26'h3FFFFFF, 8'd127, {1'b1, 8'd104, 23'd0, 1'b0, 1'b0, 1'b0});
        single("t4_zero",    26'h0000000, 8'd90,  {1'b0, 8'd0,   23'd0, 1'b1, 1'b0, 1'b0});
        single("t6_ovf",     26'h1000000, 8'd255, r6a);
        single("t6_unf",     26'h0000001, 8'd3,   r6b);
        single("unf_edge",   26'h0000001, 8'd23,  {1'b0, 8'd0,   23'd0, 1'b0, 1'b0, 1'b1});
        single("unf_edge_m1",26'h0000001, 8'd24,  {1'b0, 8'd1,   23'd0, 1'b0, 1'b0, 1'b0});
        single("no_shift",   26'h0C00001, 8'd10,  {1'b0, 8'd10,  23'h400001, 1'b0, 1'b0, 1'b0});
        single("neg_carry",  26'h27FFFFD, 8'd200, {1'b1, 8'd201, 23'h400001, 1'b0, 1'b0, 1'b0});
        single("shift12",    26'h0000ABC, 8'd200, {1'b0, 8'd188, 23'h2BC000, 1'b0, 1'b0, 1'b0});

        // Stall with both stages full, then release.
        pop0 = n_pop;
        idx = 0;
        bus.out_ready = 1'b0;
        for (int c = 0; c < 5; c++) begin
            bus.in_valid = 1'b1;
            bus.in_sum   = vs_sum[idx];
            bus.in_exp   = vs_exp[idx];
            @(negedge clk);
            if (bus.in_ready) idx++;
            @(posedge clk); #1;
        end
        chk("stall_accepted", idx, 2);
        chk("stall_in_ready", bus.in_ready, 0);
        chk("stall_out_valid", bus.out_valid, 1);
        chk("stall_head", dut_res(), model(vs_sum[0], vs_exp[0]));
        bus.in_valid = 1'b0;
        stream(idx, 4 - idx, 0, cyc);
        drain();
        chk("stall_drained", n_pop - pop0, 4);

        stream(4, 8, 0, cyc);
        chk("thru_cycles", cyc, 8);
        drain();

        stream(0, 12, 1, cyc);
        drain();

        // Reset in the middle of a stalled stream.
        bus.out_ready = 1'b0;
        for (int c = 0; c < 3; c++) begin
            bus.in_valid = 1'b1; bus.in_sum = vs_sum[5 + c]; bus.in_exp = vs_exp[5 + c];
            @(posedge clk); #1;
        end
        bus.in_valid = 1'b0;
        chk("pre_rst_valid", bus.out_valid, 1);
        rst_n = 1'b0;
        #1;
        chk("midrst_out_valid", bus.out_valid, 0);
        chk("midrst_outputs", dut_res(), 0);
        repeat (2) @(posedge clk);
        #1;
        rst_n = 1'b1;
        @(posedge clk); #1;
        chk("post_rst_in_ready", bus.in_ready, 1);
        chk("post_rst_out_valid", bus.out_valid, 0);
        single("recover", 26'h0000ABC, 8'd200, {1'b0, 8'd188, 23'h2BC000, 1'b0, 1'b0, 1'b0});
        drain();
        chk("sb_empty", q.size(), 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end
endmodule
